// File: rtl/core_defs.sv
`default_nettype none
// ============================================================================
// Package     : core_defs
// Description : Shared definitions for the RV32I fetch stage. Holds the fetch
//               FSM state encoding, the default reset PC, the canonical NOP
//               encoding and a small helper for word-alignment checks.
// Revision    : 1.0 - initial release
// ============================================================================
package core_defs;

  // Default PC of the first fetch after reset (must be word aligned).
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // addi x0, x0, 0
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // Sequential fall-through distance between RV32I instructions.
  localparam logic [31:0] PC_STEP = 32'd4;

  // Clears bit 0 of a JALR target as the ISA requires.
  localparam logic [31:0] JALR_MASK = 32'hFFFF_FFFE;

  // Fetch FSM states. Three bits cover the five states; the remaining
  // encodings are unreachable and fall back to RST.
  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_VALID = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_e;

  // True when an address sits on a 4-byte boundary.
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage : core_defs
`default_nettype wire

// File: rtl/next_pc_calc.sv
`default_nettype none
// ============================================================================
// Module      : next_pc_calc
// Description : Combinational next-PC selection for the retiring instruction.
//               Chooses between the JALR target, the PC-relative branch/jump
//               target and the sequential fall-through, and flags targets
//               that are not word aligned.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   pc_i          in  32  PC of the retiring instruction
//   immin_i       in  32  sign-extended B/J immediate
//   aludataout_i  in  32  ALU result (JALR target rs1+imm)
//   aluzero_i     in   1  branch taken / jump
//   isjalr_i      in   1  retiring instruction is JALR
//   nextpc_o      out 32  selected next PC (modulo 2^32)
//   misaligned_o  out  1  nextpc_o is not 4-byte aligned
// ============================================================================
module next_pc_calc
  import core_defs::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] immin_i,
  input  logic [31:0] aludataout_i,
  input  logic        aluzero_i,
  input  logic        isjalr_i,
  output logic [31:0] nextpc_o,
  output logic        misaligned_o
);

  always_comb begin
    nextpc_o = pc_i + PC_STEP;
    if (aluzero_i && isjalr_i) begin
      // JALR: target computed by the ALU, LSB forced to zero.
      nextpc_o = aludataout_i & JALR_MASK;
    end else if (aluzero_i) begin
      // Taken branch or JAL: PC-relative, wraps silently at 2^32.
      nextpc_o = pc_i + immin_i;
    end
  end

  // Bit 0 can only be set on the PC-relative path, but bit 1 can come from
  // either target, so the check covers both low bits uniformly.
  assign misaligned_o = !is_word_aligned(nextpc_o);

endmodule : next_pc_calc
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_unit
// Description : Program counter and instruction-fetch stage of the
//               single-cycle RV32I core. Issues one fetch at a time over a
//               req/ready + rvalid memory port, presents the instruction to
//               decode/execute and advances the PC when it retires. A
//               misaligned next-PC target halts fetching until reset.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   RESET_PC      PC of the first fetch after reset (word aligned)
// Ports
//   clk           in   1  core clock, rising edge
//   rstn          in   1  asynchronous active-low reset
//   imemreq       out  1  fetch request valid
//   imemaddr      out 32  fetch address (word aligned)
//   imemready     in   1  memory accepts the request
//   imemrvalid    in   1  read data valid
//   imemrdata     in  32  instruction word
//   instvalid     out  1  instout/pcout valid
//   instready     in   1  core retires the instruction
//   instout       out 32  fetched instruction
//   pcout         out 32  PC of instout
//   aluzero       in   1  branch taken / jump (sampled on retire)
//   isjalr        in   1  retiring instruction is JALR (sampled on retire)
//   aludataout    in  32  JALR target (sampled on retire)
//   immin         in  32  B/J immediate (sampled on retire)
//   misalignerr   out  1  sticky misaligned-target flag
//   badaddr       out 32  faulting target while misalignerr is set
// ============================================================================
module fetch_pc_unit
  import core_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  // instruction memory port
  output logic        imemreq,
  output logic [31:0] imemaddr,
  input  logic        imemready,
  input  logic        imemrvalid,
  input  logic [31:0] imemrdata,
  // decode/execute handshake
  output logic        instvalid,
  input  logic        instready,
  output logic [31:0] instout,
  output logic [31:0] pcout,
  // execute results for next-PC selection
  input  logic        aluzero,
  input  logic        isjalr,
  input  logic [31:0] aludataout,
  input  logic [31:0] immin,
  // fault reporting
  output logic        misalignerr,
  output logic [31:0] badaddr
);

  fetch_state_e state_q, state_d;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instout_q, instout_d;
  logic [31:0] pcout_q, pcout_d;
  logic [31:0] badaddr_q, badaddr_d;
  logic        misalign_q, misalign_d;
  logic        imemreq_q, imemreq_d;
  logic        instvalid_q, instvalid_d;

  logic [31:0] nextpc;
  logic        nextpc_misaligned;

  // --------------------------------------------------------------------------
  // Next-PC selection
  // --------------------------------------------------------------------------
  next_pc_calc u_next_pc_calc (
    .pc_i         (pc_q),
    .immin_i      (immin),
    .aludataout_i (aludataout),
    .aluzero_i    (aluzero),
    .isjalr_i     (isjalr),
    .nextpc_o     (nextpc),
    .misaligned_o (nextpc_misaligned)
  );

  // --------------------------------------------------------------------------
  // Next-state / next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instout_d  = instout_q;
    pcout_d    = pcout_q;
    badaddr_d  = badaddr_q;
    misalign_d = misalign_q;

    case (state_q)
      ST_RST: begin
        state_d = ST_REQ;
      end

      ST_REQ: begin
        // Request and address stay put until the memory accepts.
        if (imemready) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // Only place a response is consumed, so stray or stale rvalid pulses
        // in any other state have no effect.
        if (imemrvalid) begin
          instout_d = imemrdata;
          pcout_d   = pc_q;
          state_d   = ST_VALID;
        end
      end

      ST_VALID: begin
        if (instready) begin
          if (nextpc_misaligned) begin
            // PC stays at the faulting instruction; the bad target is kept
            // for the trap handler.
            misalign_d = 1'b1;
            badaddr_d  = nextpc;
            state_d    = ST_HALT;
          end else begin
            pc_d    = nextpc;
            state_d = ST_REQ;
          end
        end
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_RST;
      end
    endcase

    // Handshake outputs are registered copies of the upcoming state so that
    // they change exactly on the clock edge that enters/leaves the state.
    imemreq_d   = (state_d == ST_REQ);
    instvalid_d = (state_d == ST_VALID);
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_RST;
      pc_q        <= RESET_PC;
      instout_q   <= 32'h0000_0000;
      pcout_q     <= RESET_PC;
      badaddr_q   <= 32'h0000_0000;
      misalign_q  <= 1'b0;
      imemreq_q   <= 1'b0;
      instvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instout_q   <= instout_d;
      pcout_q     <= pcout_d;
      badaddr_q   <= badaddr_d;
      misalign_q  <= misalign_d;
      imemreq_q   <= imemreq_d;
      instvalid_q <= instvalid_d;
    end
  end

  // The fetch address is the PC register itself; it only moves on retire,
  // so it is stable for the whole time a request is pending.
  assign imemaddr    = pc_q;
  assign imemreq     = imemreq_q;
  assign instvalid   = instvalid_q;
  assign instout     = instout_q;
  assign pcout       = pcout_q;
  assign misalignerr = misalign_q;
  assign badaddr     = badaddr_q;

endmodule : fetch_pc_unit
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pc_unit
// Description : Self-checking bench for fetch_pc_unit. Directed scenarios
//               followed by randomized fetch/retire traffic, compared against
//               a behavioural PC model kept in the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_unit;
  import core_defs::*;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0080;

  logic        clk;
  logic        rstn;
  logic        imemreq;
  logic [31:0] imemaddr;
  logic        imemready;
  logic        imemrvalid;
  logic [31:0] imemrdata;
  logic        instvalid;
  logic        instready;
  logic [31:0] instout;
  logic [31:0] pcout;
  logic        aluzero;
  logic        isjalr;
  logic [31:0] aludataout;
  logic [31:0] immin;
  logic        misalignerr;
  logic [31:0] badaddr;

  int total = 0;
  int bad   = 0;

  // Behavioural model state: architectural PC and the instruction in flight.
  logic [31:0] m_pc;
  logic [31:0] m_inst;

  fetch_pc_unit #(.RESET_PC(TB_RESET_PC)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .imemreq    (imemreq),
    .imemaddr   (imemaddr),
    .imemready  (imemready),
    .imemrvalid (imemrvalid),
    .imemrdata  (imemrdata),
    .instvalid  (instvalid),
    .instready  (instready),
    .instout    (instout),
    .pcout      (pcout),
    .aluzero    (aluzero),
    .isjalr     (isjalr),
    .aludataout (aludataout),
    .immin      (immin),
    .misalignerr(misalignerr),
    .badaddr    (badaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // RV32I next-PC rule, straight from the ISA description.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic z, input logic j,
                                           input logic [31:0] alu, input logic [31:0] imm);
    logic [31:0] t;
    if (z && j)      t = {alu[31:1], 1'b0};
    else if (z)      t = pc + imm;
    else             t = pc + 32'd4;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic randomize_dontcare();
    aluzero    = 1'($urandom_range(0, 1));
    isjalr     = 1'($urandom_range(0, 1));
    aludataout = $urandom;
    immin      = $urandom;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_imemreq"},   {31'd0, imemreq},     32'd0);
    chk({tag, "_imemaddr"},  imemaddr,             TB_RESET_PC);
    chk({tag, "_instvalid"}, {31'd0, instvalid},   32'd0);
    chk({tag, "_instout"},   instout,              32'd0);
    chk({tag, "_pcout"},     pcout,                TB_RESET_PC);
    chk({tag, "_misalign"},  {31'd0, misalignerr}, 32'd0);
    chk({tag, "_badaddr"},   badaddr,              32'd0);
  endtask

  // Called at a negedge. Asserts reset mid-cycle, checks the asynchronous
  // effect, releases it and checks the request appears one cycle later.
  task automatic do_reset(input string tag, input logic stray);
    rstn = 1'b0; imemready = 1'b0; instready = 1'b0; imemrvalid = 1'b0;
    #1;
    check_reset_vals({tag, "_async"});
    @(negedge clk);
    check_reset_vals({tag, "_hold"});
    imemrvalid = stray;
    imemrdata  = 32'hDEAD_BEEF;
    rstn = 1'b1;
    #1;
    chk({tag, "_rst_noreq"}, {31'd0, imemreq}, 32'd0);
    @(negedge clk);
    chk({tag, "_first_req"},  {31'd0, imemreq}, 32'd1);
    chk({tag, "_first_addr"}, imemaddr, TB_RESET_PC);
    m_pc = TB_RESET_PC;
  endtask

  // Called at a negedge. Serves one fetch with the given memory delays.
  task automatic do_fetch(input logic [31:0] data, input int rdy_dly, input int rv_dly);
    int n = 0;
    while (!imemreq && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", {31'd0, imemreq}, 32'd1);
    chk("req_addr", imemaddr, m_pc);
    for (int i = 0; i < rdy_dly; i++) begin
      // A stray response while the request is still pending must be ignored.
      imemready  = 1'b0;
      imemrvalid = 1'b1;
      imemrdata  = $urandom;
      @(negedge clk);
      chk("req_hold",  {31'd0, imemreq}, 32'd1);
      chk("addr_hold", imemaddr, m_pc);
    end
    imemrvalid = 1'b0;
    imemready  = 1'b1;
    @(negedge clk);
    imemready = 1'b0;
    chk("req_drop", {31'd0, imemreq}, 32'd0);
    for (int i = 0; i < rv_dly; i++) begin
      @(negedge clk);
      chk("wait_noval", {31'd0, instvalid}, 32'd0);
    end
    imemrvalid = 1'b1;
    imemrdata  = data;
    @(negedge clk);
    imemrvalid = 1'b0;
    imemrdata  = $urandom;
    chk("instvalid", {31'd0, instvalid}, 32'd1);
    chk("instout",   instout, data);
    chk("pcout",     pcout,   m_pc);
    m_inst = data;
  endtask

  // Called at a negedge with an instruction valid. Stalls, then retires it.
  task automatic do_retire(input int stall, input logic z, input logic j,
                           input logic [31:0] alu, input logic [31:0] imm,
                           output logic halted);
    logic [31:0] nxt;
    for (int i = 0; i < stall; i++) begin
      instready = 1'b0;
      randomize_dontcare();
      @(negedge clk);
      chk("stall_valid",   {31'd0, instvalid}, 32'd1);
      chk("stall_instout", instout, m_inst);
      chk("stall_pcout",   pcout,   m_pc);
      chk("stall_noreq",   {31'd0, imemreq}, 32'd0);
    end
    instready  = 1'b1;
    aluzero    = z;
    isjalr     = j;
    aludataout = alu;
    immin      = imm;
    nxt = ref_next(m_pc, z, j, alu, imm);
    @(negedge clk);
    instready = 1'b0;
    randomize_dontcare();
    chk("ret_valid_drop", {31'd0, instvalid}, 32'd0);
    if (nxt[1:0] == 2'b00) begin
      halted = 1'b0;
      m_pc = nxt;
      chk("ret_req",      {31'd0, imemreq}, 32'd1);
      chk("ret_addr",     imemaddr, nxt);
      chk("ret_misalign", {31'd0, misalignerr}, 32'd0);
    end else begin
      halted = 1'b1;
      chk("halt_misalign", {31'd0, misalignerr}, 32'd1);
      chk("halt_badaddr",  badaddr, nxt);
      chk("halt_noreq",    {31'd0, imemreq}, 32'd0);
      for (int i = 0; i < 3; i++) begin
        imemrvalid = 1'b1;
        instready  = 1'b1;
        @(negedge clk);
        chk("halt_stay_noreq", {31'd0, imemreq}, 32'd0);
        chk("halt_stay_noval", {31'd0, instvalid}, 32'd0);
        chk("halt_sticky",     {31'd0, misalignerr}, 32'd1);
        chk("halt_bad_keep",   badaddr, nxt);
      end
      imemrvalid = 1'b0;
      instready  = 1'b0;
    end
  endtask

  initial begin
    logic        h;
    logic        z, j;
    logic [31:0] alu, imm;

    rstn = 1'b0; imemready = 1'b0; imemrvalid = 1'b0; imemrdata = 32'd0;
    instready = 1'b0; aluzero = 1'b0; isjalr = 1'b0; aludataout = 32'd0; immin = 32'd0;
    m_pc = TB_RESET_PC; m_inst = 32'd0;

    @(negedge clk);
    // Reset and first fetch with zero-wait memory.
    do_reset("rst0", 1'b0);
    do_fetch(INST_NOP, 0, 0);

    // Sequential, wrap at 2^32.
    do_retire(0, 1'b0, 1'b0, 32'h0, 32'h0, h);                  // -> 0x84
    do_fetch($urandom, 0, 0);
    do_retire(0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FF78, h);          // -> 0xFFFFFFFC
    do_fetch($urandom, 0, 0);
    do_retire(0, 1'b0, 1'b0, 32'h0, 32'h0, h);                  // -> 0x0
    do_fetch($urandom, 0, 1);

    // Branches.
    do_retire(0, 1'b1, 1'b1, 32'h0000_0101, 32'h0, h);          // -> 0x100
    do_fetch($urandom, 1, 0);
    do_retire(0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFF0, h);          // -> 0xF0
    do_fetch($urandom, 0, 0);
    do_retire(1, 1'b1, 1'b1, 32'h0000_0100, 32'h0, h);          // -> 0x100
    do_fetch($urandom, 0, 0);
    do_retire(0, 1'b1, 1'b0, 32'h0, 32'h0000_0008, h);          // -> 0x108
    do_fetch($urandom, 0, 0);
    do_retire(0, 1'b0, 1'b1, 32'h0000_0500, 32'h0000_0040, h);  // jalr not taken -> 0x10C
    do_fetch($urandom, 0, 0);

    // JALR, then backpressure on both sides, then misaligned JALR.
    do_retire(0, 1'b1, 1'b1, 32'h0000_0205, 32'h0, h);          // -> 0x204
    do_fetch($urandom, 3, 2);
    do_retire(5, 1'b1, 1'b1, 32'h0000_0203, 32'h0, h);          // -> halt, bad 0x202
    chk("jalr_halted", {31'd0, h}, 32'd1);

    // Reset while waiting for a response; stray response around reset.
    do_reset("rst1", 1'b1);
    imemready = 1'b1;
    @(negedge clk);
    imemready = 1'b0;
    chk("in_wait", {31'd0, imemreq}, 32'd0);
    do_reset("rst_wait", 1'b1);
    do_fetch(32'h1234_5678, 2, 0);

    // Reset while an instruction is presented.
    do_retire(0, 1'b0, 1'b0, 32'h0, 32'h0, h);
    do_fetch(32'h0BAD_F00D, 0, 0);
    do_reset("rst_valid", 1'b0);
    do_fetch($urandom, 0, 0);

    // Randomized traffic.
    for (int it = 0; it < 60; it++) begin
      z   = 1'($urandom_range(0, 1));
      j   = 1'($urandom_range(0, 1));
      alu = $urandom;
      imm = $urandom;
      if ($urandom_range(0, 7) != 0) alu[1] = 1'b0;
      if ($urandom_range(0, 7) != 0) imm[1:0] = 2'b00;
      do_retire(int'($urandom_range(0, 3)), z, j, alu, imm, h);
      if (h) do_reset("rst_rand", 1'($urandom_range(0, 1)));
      do_fetch($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fetch_pc_unit
`default_nettype wire
